// File: rtl/cotm32_trap_csr_unit.sv
// rtl/cotm32_trap_csr_unit.sv - M-mode trap/mret responder holding mtvec, mepc, mcause, mtval with Zicsr access
module cotm32_trap_csr_unit #(
  parameter int unsigned       MXLEN       = 32,
  parameter logic [MXLEN-1:0]  MTVEC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [MXLEN-1:0] csr_wdata,
  output logic [MXLEN-1:0] csr_rdata,
  output logic             csr_illegal,
  input  logic             trap_req,
  input  logic [MXLEN-1:0] trap_cause,
  input  logic [MXLEN-1:0] trap_pc,
  input  logic [MXLEN-1:0] trap_val,
  output logic             trap_ack,
  input  logic             mret_req,
  output logic             mret_ack,
  output logic             redirect_valid,
  output logic [MXLEN-1:0] redirect_pc,
  output logic             busy
);

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } zicsr_csr_op_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP_REDIR = 2'd1,
    MRET_REDIR = 2'd2
  } state_t;

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  // Direct-mode mtvec and IALIGN=32 mepc keep their low two bits at zero.
  localparam logic [MXLEN-1:0] ALIGN_MASK = {{(MXLEN-2){1'b1}}, 2'b00};

  state_t           state;
  logic [MXLEN-1:0] mtvec;
  logic [MXLEN-1:0] mepc;
  logic [MXLEN-1:0] mcause;
  logic [MXLEN-1:0] mtval;

  logic [MXLEN-1:0] rd_val;
  logic [MXLEN-1:0] wr_val;
  logic             addr_impl;
  logic             op_active;
  logic             csr_we;

  always_comb begin
    rd_val    = '0;
    addr_impl = 1'b1;
    case (csr_addr)
      ADDR_MTVEC:  rd_val = mtvec;
      ADDR_MEPC:   rd_val = mepc;
      ADDR_MCAUSE: rd_val = mcause;
      ADDR_MTVAL:  rd_val = mtval;
      default:     addr_impl = 1'b0;
    endcase

    op_active   = (csr_op != CSR_NONE);
    csr_illegal = op_active && !addr_impl;
    csr_rdata   = op_active ? rd_val : '0;

    case (csr_op)
      CSR_RW:  wr_val = csr_wdata;
      CSR_RS:  wr_val = rd_val | csr_wdata;
      CSR_RC:  wr_val = rd_val & ~csr_wdata;
      default: wr_val = rd_val;
    endcase

    // Trap and mret entry take priority; a coincident CSR write is dropped.
    csr_we = (state == IDLE) && op_active && addr_impl && !trap_req && !mret_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mtvec          <= MTVEC_RESET & ALIGN_MASK;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      trap_ack       <= 1'b0;
      mret_ack       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      trap_ack       <= 1'b0;
      mret_ack       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
      case (state)
        IDLE: begin
          if (trap_req) begin
            mepc           <= trap_pc & ALIGN_MASK;
            mcause         <= trap_cause;
            mtval          <= trap_val;
            state          <= TRAP_REDIR;
            trap_ack       <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mtvec;
            busy           <= 1'b1;
          end else if (mret_req) begin
            state          <= MRET_REDIR;
            mret_ack       <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
            busy           <= 1'b1;
          end else if (csr_we) begin
            case (csr_addr)
              ADDR_MTVEC:  mtvec  <= wr_val & ALIGN_MASK;
              ADDR_MEPC:   mepc   <= wr_val & ALIGN_MASK;
              ADDR_MCAUSE: mcause <= wr_val;
              ADDR_MTVAL:  mtval  <= wr_val;
              default:     ;
            endcase
          end
        end
        TRAP_REDIR: state <= IDLE;
        MRET_REDIR: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cotm32_trap_csr_unit.sv
// tb/tb_cotm32_trap_csr_unit.sv - directed scoreboard bench for cotm32_trap_csr_unit
module tb_cotm32_trap_csr_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1007;
  localparam logic [31:0] MTVEC_EXP = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        trap_ack;
  logic        mret_req;
  logic        mret_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  cotm32_trap_csr_unit #(.MXLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .trap_ack(trap_ack), .mret_req(mret_req), .mret_ack(mret_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  task automatic push(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] observed);
    exp_t e;
    if (q.size() == 0) begin
      n_compared++;
      n_failed++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", observed);
    end else begin
      e = q.pop_front();
      n_compared++;
      assert (observed === e.value)
      else begin
        n_failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  // Side-effect-free read: RS with zero mask.
  task automatic read_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    csr_op = 2'd2; csr_addr = addr; csr_wdata = '0;
    push(tag, exp);
    push({tag, "_illegal"}, 32'd0);
    #1;
    pop_check(csr_rdata);
    pop_check({31'd0, csr_illegal});
    csr_op = 2'd0;
  endtask

  task automatic write_csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk);
    csr_op = op; csr_addr = addr; csr_wdata = wd;
    @(posedge clk);
    #1;
    csr_op = 2'd0; csr_wdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    csr_op = 2'd0; csr_addr = '0; csr_wdata = '0;
    trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0;
    mret_req = 1'b0;
    repeat (2) @(negedge clk);
    push("rst_redirect_valid", 32'd0); pop_check({31'd0, redirect_valid});
    push("rst_busy", 32'd0);           pop_check({31'd0, busy});
    push("rst_trap_ack", 32'd0);       pop_check({31'd0, trap_ack});
    rst = 1'b0;

    // Reset values
    read_csr("rst_mtvec", 12'h305, MTVEC_EXP);
    read_csr("rst_mepc", 12'h341, 32'd0);
    read_csr("rst_mcause", 12'h342, 32'd0);
    read_csr("rst_mtval", 12'h343, 32'd0);

    // RW/RS/RC with WARL masking
    write_csr(2'd1, 12'h305, 32'h8000_0103);
    read_csr("rw_mtvec_warl", 12'h305, 32'h8000_0100);
    write_csr(2'd2, 12'h342, 32'h5);
    read_csr("rs_mcause", 12'h342, 32'h5);
    write_csr(2'd3, 12'h342, 32'h1);
    read_csr("rc_mcause", 12'h342, 32'h4);
    write_csr(2'd2, 12'h342, 32'h0);
    read_csr("rs_zero_keeps", 12'h342, 32'h4);

    // Trap entry
    write_csr(2'd1, 12'h305, 32'h100);
    @(negedge clk);
    trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h2002; trap_val = 32'hDEAD;
    push("trap_rv", 32'd1); push("trap_pc", 32'h100); push("trap_ack", 32'd1);
    push("trap_busy", 32'd1); push("trap_no_mret_ack", 32'd0);
    @(posedge clk); #1;
    pop_check({31'd0, redirect_valid}); pop_check(redirect_pc); pop_check({31'd0, trap_ack});
    pop_check({31'd0, busy}); pop_check({31'd0, mret_ack});
    trap_req = 1'b0;
    push("trap_rv_drop", 32'd0); push("trap_pc_zero", 32'd0); push("trap_busy_drop", 32'd0);
    @(posedge clk); #1;
    pop_check({31'd0, redirect_valid}); pop_check(redirect_pc); pop_check({31'd0, busy});
    read_csr("trap_mepc", 12'h341, 32'h2000);
    read_csr("trap_mcause", 12'h342, 32'd2);
    read_csr("trap_mtval", 12'h343, 32'hDEAD);

    // mret
    write_csr(2'd1, 12'h341, 32'h403);
    read_csr("mepc_warl", 12'h341, 32'h400);
    @(negedge clk);
    mret_req = 1'b1;
    push("mret_rv", 32'd1); push("mret_pc", 32'h400); push("mret_ack", 32'd1); push("mret_no_trap_ack", 32'd0);
    @(posedge clk); #1;
    pop_check({31'd0, redirect_valid}); pop_check(redirect_pc); pop_check({31'd0, mret_ack});
    pop_check({31'd0, trap_ack});
    mret_req = 1'b0;
    read_csr("mret_mcause_kept", 12'h342, 32'd2);

    // Trap + mret + CSR write together; write during busy dropped
    @(negedge clk);
    trap_req = 1'b1; mret_req = 1'b1; trap_cause = 32'd7; trap_pc = 32'h3000; trap_val = 32'hBEEF;
    csr_op = 2'd1; csr_addr = 12'h343; csr_wdata = 32'h1234;
    push("prio_trap_ack", 32'd1); push("prio_mret_ack", 32'd0); push("prio_pc", 32'h100);
    @(posedge clk); #1;
    pop_check({31'd0, trap_ack}); pop_check({31'd0, mret_ack}); pop_check(redirect_pc);
    trap_req = 1'b0;
    csr_op = 2'd1; csr_addr = 12'h342; csr_wdata = 32'h55;
    push("busy_mret_ignored", 32'd0); push("busy_rv_low", 32'd0);
    @(posedge clk); #1;
    pop_check({31'd0, mret_ack}); pop_check({31'd0, redirect_valid});
    csr_op = 2'd0; csr_wdata = '0;
    push("held_mret_ack", 32'd1); push("held_mret_pc", 32'h3000);
    @(posedge clk); #1;
    pop_check({31'd0, mret_ack}); pop_check(redirect_pc);
    mret_req = 1'b0;
    read_csr("prio_mtval", 12'h343, 32'hBEEF);
    read_csr("busy_write_dropped", 12'h342, 32'd7);

    // Illegal address
    @(negedge clk);
    csr_op = 2'd1; csr_addr = 12'h300; csr_wdata = 32'hFFFF_FFFF;
    push("illegal_flag", 32'd1); push("illegal_rdata", 32'd0);
    #1;
    pop_check({31'd0, csr_illegal}); pop_check(csr_rdata);
    @(posedge clk); #1;
    csr_op = 2'd0; csr_wdata = '0;
    read_csr("illegal_no_change", 12'h305, 32'h100);

    // Reset during TRAP_REDIR
    @(negedge clk);
    trap_req = 1'b1; trap_cause = 32'd3; trap_pc = 32'h5000; trap_val = 32'h1;
    push("pre_rst_rv", 32'd1);
    @(posedge clk); #1;
    pop_check({31'd0, redirect_valid});
    rst = 1'b1;
    #1;
    push("rst_mid_rv", 32'd0); push("rst_mid_ack", 32'd0); push("rst_mid_pc", 32'd0);
    pop_check({31'd0, redirect_valid}); pop_check({31'd0, trap_ack}); pop_check(redirect_pc);
    trap_req = 1'b0;
    read_csr("rst_mid_mtvec", 12'h305, MTVEC_EXP);
    read_csr("rst_mid_mepc", 12'h341, 32'd0);
    read_csr("rst_mid_mcause", 12'h342, 32'd0);
    read_csr("rst_mid_mtval", 12'h343, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push("post_rst_busy", 32'd0);
    @(posedge clk); #1;
    pop_check({31'd0, busy});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
